// File: rtl/axis_framer_pkg.sv
// axis_framer_pkg: sizing and packet-length helpers shared by the framer files.
package axis_framer_pkg;

    function automatic int len_bits(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

    // A zero length still produces one-beat packets; oversize lengths saturate.
    function automatic int clamp_len(input int len, input int max_len);
        return (len == 0) ? 1 : (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg: single-entry AXI-Stream output register with load and stall.
module axis_out_reg #(
    parameter int W = 8
) (
    input  logic         aclk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] data_in,
    input  logic         last_in,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         last
);

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
            last  <= last_in;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_pkt_framer.sv
// axis_pkt_framer: AXI-Stream framer closing packets by length, upstream tlast or idle timeout.
module axis_pkt_framer
    import axis_framer_pkg::*;
#(
    parameter int TDATA_WIDTH    = 8,
    parameter int MAX_PKT_LENGTH = 256,
    parameter int TIMEOUT_WIDTH  = 16,
    parameter int LEN_W          = len_bits(MAX_PKT_LENGTH)
) (
    input  logic                     aclk,
    input  logic                     resetn,
    input  logic [LEN_W-1:0]         pkt_length,
    input  logic [TIMEOUT_WIDTH-1:0] idle_timeout,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                     s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic                     m_axis_tlast,
    output logic [LEN_W-1:0]         o_cnt,
    output logic [31:0]              o_pkt_count,
    output logic                     o_flush
);

    logic                     pend_valid;
    logic                     pend_final;
    logic [TDATA_WIDTH-1:0]   pend_data;
    logic [LEN_W-1:0]         cnt;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         len_in;
    logic [LEN_W-1:0]         len_eff;
    logic [LEN_W:0]           cnt_nxt;
    logic [TIMEOUT_WIDTH-1:0] idle_cnt;
    logic [TIMEOUT_WIDTH-1:0] idle_lim;
    logic                     out_space;
    logic                     acc;
    logic                     final_in;
    logic                     timeout_hit;
    logic                     move;

    assign out_space     = ~m_axis_tvalid | m_axis_tready;
    assign s_axis_tready = ~pend_valid | out_space;
    assign acc           = s_axis_tvalid & s_axis_tready;
    assign len_in        = LEN_W'(clamp_len(int'(pkt_length), MAX_PKT_LENGTH));
    assign len_eff       = (cnt == '0) ? len_in : len_q;
    assign cnt_nxt       = {1'b0, cnt} + {{LEN_W{1'b0}}, 1'b1};
    assign final_in      = s_axis_tlast | (cnt_nxt >= {1'b0, len_eff});
    assign idle_lim      = idle_timeout - {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
    assign o_cnt         = cnt;

    // An accept always outranks the timeout, so a beat is never flushed once a successor arrives.
    assign timeout_hit = pend_valid & ~pend_final & (idle_timeout != '0) &
                         (idle_cnt == idle_lim) & ~acc & out_space;
    assign move        = pend_valid & out_space & (pend_final | acc | timeout_hit);

    axis_out_reg #(.W(TDATA_WIDTH)) u_out (
        .aclk    (aclk),
        .resetn  (resetn),
        .load    (move),
        .data_in (pend_data),
        .last_in (pend_final | timeout_hit),
        .ready   (m_axis_tready),
        .valid   (m_axis_tvalid),
        .data    (m_axis_tdata),
        .last    (m_axis_tlast)
    );

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            pend_valid  <= 1'b0;
            pend_final  <= 1'b0;
            pend_data   <= '0;
            cnt         <= '0;
            len_q       <= '0;
            idle_cnt    <= '0;
            o_pkt_count <= '0;
            o_flush     <= 1'b0;
        end else begin
            if (acc) begin
                pend_valid <= 1'b1;
                pend_final <= final_in;
                pend_data  <= s_axis_tdata;
            end else if (move) begin
                pend_valid <= 1'b0;
            end
            if (acc && cnt == '0)
                len_q <= len_in;
            if (acc)
                cnt <= final_in ? '0 : cnt_nxt[LEN_W-1:0];
            else if (timeout_hit)
                cnt <= '0;
            // Saturating at the limit keeps a blocked flush armed until the output frees up.
            if (acc | ~pend_valid | timeout_hit)
                idle_cnt <= '0;
            else if (~pend_final && idle_cnt != idle_lim)
                idle_cnt <= idle_cnt + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
            o_flush <= timeout_hit;
            if (m_axis_tvalid & m_axis_tready & m_axis_tlast)
                o_pkt_count <= o_pkt_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_axis_pkt_framer.sv
// tb_axis_pkt_framer: randomized framer bench scored against a beat-level packet model.
module tb_axis_pkt_framer;

    localparam int MAXL = 256;
    localparam int LW   = 9;
    localparam int NB   = 1024;

    logic          aclk;
    logic          resetn;
    logic [LW-1:0] pkt_length;
    logic [15:0]   idle_timeout;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [7:0]    s_axis_tdata;
    logic          s_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tlast;
    logic [LW-1:0] o_cnt;
    logic [31:0]   o_pkt_count;
    logic          o_flush;

    axis_pkt_framer dut (
        .aclk          (aclk),
        .resetn        (resetn),
        .pkt_length    (pkt_length),
        .idle_timeout  (idle_timeout),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .o_cnt         (o_cnt),
        .o_pkt_count   (o_pkt_count),
        .o_flush       (o_flush)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int eff_len(input int v);
        return (v == 0) ? 1 : (v > MAXL) ? MAXL : v;
    endfunction

    initial begin
        aclk = 0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    bit rdy_rand = 0;
    bit rdy_fix  = 1;
    initial begin
        m_axis_tready = 1;
        forever begin
            @(posedge aclk);
            #1;
            m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    // Reference model: each accepted beat is tagged with its expected tlast, flush flag and emit time.
    logic [7:0] exp_data  [NB];
    bit         exp_last  [NB];
    bit         exp_flush [NB];
    int         exp_emit  [NB];
    logic [7:0] obs_data  [NB];
    bit         obs_last  [NB];
    bit         obs_flush [NB];
    int         obs_cyc   [NB];
    int cyc = 0, n_acc = 0, n_obs = 0, m_cnt = 0, m_len = 1, pend_idx = -1, last_acc = 0;
    int exp_pkts = 0, exp_flushes = 0, obs_flushes = 0, exp_cnt = 0;
    bit chk_cnt = 0, prev_stall = 0, prev_v = 0, prev_l = 0, fin = 0;
    logic [7:0] prev_d = 0;

    initial forever begin
        @(negedge aclk);
        cyc++;
        if (!resetn) begin
            n_acc = 0; n_obs = 0; m_cnt = 0; pend_idx = -1; exp_pkts = 0;
            exp_flushes = 0; obs_flushes = 0; chk_cnt = 0; prev_stall = 0;
        end else begin
            if (chk_cnt) check("o_cnt", 64'(o_cnt), 64'(exp_cnt));
            chk_cnt = 0;
            if (prev_stall) begin
                check("stall_valid", 64'(m_axis_tvalid), 64'(prev_v));
                check("stall_data", 64'(m_axis_tdata), 64'(prev_d));
                check("stall_last", 64'(m_axis_tlast), 64'(prev_l));
            end
            prev_stall = m_axis_tvalid & ~m_axis_tready;
            prev_v = m_axis_tvalid; prev_d = m_axis_tdata; prev_l = m_axis_tlast;
            if (o_flush) obs_flushes++;
            if (m_axis_tvalid && m_axis_tready && n_obs < NB) begin
                obs_data[n_obs] = m_axis_tdata;
                obs_last[n_obs] = m_axis_tlast;
                obs_flush[n_obs] = o_flush;
                obs_cyc[n_obs] = cyc;
                n_obs++;
            end
            if (s_axis_tvalid && s_axis_tready && n_acc < NB) begin
                if (pend_idx >= 0) exp_emit[pend_idx] = cyc + 1;
                if (m_cnt == 0) m_len = eff_len(int'(pkt_length));
                m_cnt++;
                fin = s_axis_tlast || m_cnt >= m_len;
                exp_data[n_acc] = s_axis_tdata;
                exp_last[n_acc] = fin;
                exp_flush[n_acc] = 0;
                if (fin) begin
                    exp_emit[n_acc] = cyc + 2;
                    m_cnt = 0;
                    exp_pkts++;
                    pend_idx = -1;
                end else begin
                    pend_idx = n_acc;
                end
                n_acc++;
                exp_cnt = m_cnt;
                chk_cnt = 1;
                last_acc = cyc;
            end else if (pend_idx >= 0 && idle_timeout != 0 && cyc - last_acc == int'(idle_timeout)) begin
                exp_last[pend_idx] = 1;
                exp_flush[pend_idx] = 1;
                exp_emit[pend_idx] = cyc + 1;
                m_cnt = 0;
                exp_pkts++;
                exp_flushes++;
                pend_idx = -1;
            end
        end
    end

    int base = 0;

    task automatic send(input logic [7:0] d, input logic tl);
        int k = 0;
        s_axis_tvalid = 1;
        s_axis_tdata = d;
        s_axis_tlast = tl;
        @(negedge aclk);
        while (!s_axis_tready && k < 300) begin
            @(negedge aclk);
            k++;
        end
        if (!s_axis_tready) check("send_wait", 64'(s_axis_tready), 64'd1);
        @(posedge aclk);
        #1;
        s_axis_tvalid = 0;
        s_axis_tlast = 0;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic finish_phase(input string ph, input bit lat);
        int k = 0;
        while (n_obs < n_acc && k < 600) begin
            @(negedge aclk);
            k++;
        end
        repeat (2) @(negedge aclk);
        check($sformatf("%s.beats", ph), 64'(n_obs), 64'(n_acc));
        for (int i = base; i < n_acc && i < n_obs; i++) begin
            check($sformatf("%s.data[%0d]", ph, i), 64'(obs_data[i]), 64'(exp_data[i]));
            check($sformatf("%s.last[%0d]", ph, i), 64'(obs_last[i]), 64'(exp_last[i]));
            check($sformatf("%s.flush[%0d]", ph, i), 64'(obs_flush[i]), 64'(exp_flush[i]));
            if (lat) check($sformatf("%s.emit[%0d]", ph, i), 64'(obs_cyc[i]), 64'(exp_emit[i]));
        end
        check($sformatf("%s.pkt_count", ph), 64'(o_pkt_count), 64'(exp_pkts));
        check($sformatf("%s.flushes", ph), 64'(obs_flushes), 64'(exp_flushes));
        base = n_acc;
        @(posedge aclk);
        #1;
    endtask

    task automatic check_reset_state(input string ph);
        check({ph, ".m_valid"}, 64'(m_axis_tvalid), 64'd0);
        check({ph, ".m_last"}, 64'(m_axis_tlast), 64'd0);
        check({ph, ".m_data"}, 64'(m_axis_tdata), 64'd0);
        check({ph, ".o_cnt"}, 64'(o_cnt), 64'd0);
        check({ph, ".pkt_count"}, 64'(o_pkt_count), 64'd0);
        check({ph, ".o_flush"}, 64'(o_flush), 64'd0);
        check({ph, ".s_ready"}, 64'(s_axis_tready), 64'd1);
    endtask

    initial begin
        resetn = 0;
        pkt_length = 4;
        idle_timeout = 0;
        s_axis_tvalid = 0;
        s_axis_tdata = 0;
        s_axis_tlast = 0;
        repeat (3) @(posedge aclk);
        #1;
        resetn = 1;
        @(negedge aclk);
        check_reset_state("reset");
        @(posedge aclk);
        #1;

        for (int i = 0; i < 12; i++) send(8'(i), 0);
        finish_phase("len4", 1);

        for (int i = 0; i < 6; i++) send(8'(i), i == 1);
        finish_phase("tlast", 1);

        pkt_length = 8;
        idle_timeout = 5;
        send(8'd20, 0); send(8'd21, 0); send(8'd22, 0);
        idle(12);
        send(8'd23, 0); send(8'd24, 0);
        idle(12);
        send(8'd30, 0);
        idle(4);
        send(8'd31, 0);
        idle(5);
        send(8'd32, 0);
        finish_phase("timeout", 1);

        for (int i = 0; i < 40; i++) begin
            pkt_length = LW'($urandom_range(0, 6));
            send(8'($urandom), $urandom_range(0, 9) == 0);
            idle($urandom_range(0, 7));
        end
        finish_phase("rand_tmo", 1);
        idle_timeout = 0;

        rdy_rand = 1;
        pkt_length = 3;
        for (int i = 0; i < 60; i++) begin
            send(8'(100 + i), 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        finish_phase("backpressure", 0);
        rdy_rand = 0;
        rdy_fix = 1;
        idle(2);

        pkt_length = 4;
        send(8'd40, 0); send(8'd41, 0);
        pkt_length = 2;
        for (int i = 42; i < 48; i++) send(8'(i), 0);
        finish_phase("len_change", 1);

        pkt_length = 0;
        for (int i = 0; i < 3; i++) send(8'(60 + i), 0);
        pkt_length = 300;
        for (int i = 0; i < 260; i++) send(8'(i), i == 259);
        finish_phase("len_edges", 1);

        pkt_length = 4;
        rdy_fix = 0;
        idle(2);
        send(8'd70, 0); send(8'd71, 0);
        resetn = 0;
        @(posedge aclk);
        #1;
        resetn = 1;
        @(negedge aclk);
        check_reset_state("midreset");
        base = 0;
        rdy_fix = 1;
        idle(3);
        for (int i = 0; i < 4; i++) send(8'(80 + i), 0);
        finish_phase("after_reset", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_pkt_framer.md
# axis_pkt_framer

AXI-Stream packet framer that inserts `m_axis_tlast` on a single stream, with optional early termination from upstream `tlast` and an idle-timeout flush. It sits between a continuous sample source (ADC or DSP chain) and a DMA or packet sink, replacing the pass-through tlast generator.

Unlike that generator, it:
- has registered outputs;
- latches the packet length once per packet;
- closes a partial packet when the source goes idle.

## Interface
- `TDATA_WIDTH`, 8, data width in bits.
- `MAX_PKT_LENGTH`, 256, largest packet in beats; `LEN_W = $clog2(MAX_PKT_LENGTH)+1`.
- `TIMEOUT_WIDTH`, 16, width of the idle-timeout counter.

- `aclk`  in  1  clock, all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `pkt_length`  in  LEN_W  packet length in beats, sampled on the first beat of each packet.
- `idle_timeout`  in  TIMEOUT_WIDTH  idle cycles before a partial packet is flushed; 0 disables the flush.
- `s_axis_tvalid`  in  1  upstream valid.
- `s_axis_tready`  out  1  upstream ready.
- `s_axis_tdata`  in  TDATA_WIDTH  upstream data.
- `s_axis_tlast`  in  1  upstream end-of-packet; forces the current beat to be final.
- `m_axis_tvalid`  out  1  downstream valid, registered.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tdata`  out  TDATA_WIDTH  downstream data, registered.
- `m_axis_tlast`  out  1  downstream end-of-packet, registered.
- `o_cnt`  out  LEN_W  beats accepted in the current packet.
- `o_pkt_count`  out  32  packets completed downstream; wraps at 2^32.
- `o_flush`  out  1  one-cycle pulse when a timeout flush closes a packet.

## Operation
- Two storage stages:
  - PEND is hidden and holds the last accepted beat until its tlast is decided.
  - OUT is the visible output register.
- Definitions:
  - `acc = s_axis_tvalid & s_axis_tready`
  - `out_space = ~out_valid | m_axis_tready`
  - `s_axis_tready = ~pend_valid | out_space`
- Length latch: on `acc` with `cnt == 0`, set `len_q = pkt_length`.
  - 0 is treated as 1.
  - Values above `MAX_PKT_LENGTH` are clamped to `MAX_PKT_LENGTH`.
- On `acc`, the beat enters PEND with `pend_final = s_axis_tlast | (cnt+1 >= len_eff)`.
  - If final, `cnt <= 0`; otherwise `cnt <= cnt+1`.
  - `len_eff` is the latched value, or the incoming value on a first beat.
- PEND moves to OUT, only when `out_space`, under exactly one of these causes:
  - `pend_final`: moves with tlast = 1.
  - `acc` this cycle: moves with tlast = 0.
  - Timeout hit: moves with tlast = 1, pulses `o_flush`, and sets `cnt <= 0`.
- Idle counter:
  - Increments while PEND holds a non-final beat and no `acc` occurs.
  - Clears on `acc` or whenever PEND is empty.
- Timeout hit: `idle_cnt == idle_timeout - 1`, `idle_timeout != 0`, no `acc`, and `out_space`.
  - If the hit is blocked by `~out_space`, the counter saturates and the flush fires on the first cycle `out_space` returns.
- Simultaneous `acc` and timeout: `acc` wins; the pending beat leaves with tlast = 0 and there is no flush.
- `o_pkt_count` increments on `m_axis_tvalid & m_axis_tready & m_axis_tlast`.
- Reset mid-packet discards PEND and OUT contents; no partial tlast is emitted.

## Timing
- Reset values: `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `o_cnt`, `o_pkt_count`, `o_flush`, `pend_valid`, `idle_cnt` all 0.
- `s_axis_tready` is 1 after reset.
- Final beat accepted at edge E0 appears on `m_axis_*` after E1.
- Non-final beat appears after the edge that accepts its successor, or after the timeout-hit edge.
- Sustains one beat per cycle with `m_axis_tready = 1`, including across packet boundaries.
- `m_axis_*` are held stable while `m_axis_tvalid & ~m_axis_tready`, per AXI-Stream.
- `s_axis_tready` depends on `m_axis_tready` combinationally, with no path from `s_axis_tvalid`.
- Timeout flush occurs `idle_timeout` cycles after the last accept.

## Structure
- Package `axis_framer_pkg`: `LEN_W` helper function and the clamp function for `pkt_length`.
- Sub-module `axis_out_reg`: single-entry output register holding valid/data/last with load and stall, instantiated for OUT.
- PEND, the counters and the flush logic live in the top level.

## Test plan
- `pkt_length = 4`, continuous input 0..11, `m_axis_tready = 1`:
  - tlast on data 3, 7, 11;
  - one beat per cycle;
  - `o_pkt_count = 3`.
- `pkt_length = 4`, `s_axis_tlast` on the 2nd beat: packets are {0,1}, {2,3,4,5}; `o_cnt` returns to 0 after beat 1.
- `idle_timeout = 5`, 3 beats then idle:
  - beat 2 emitted with tlast exactly 5 cycles after its accept;
  - `o_flush` pulses once;
  - the next beat starts a new packet.
- Random `m_axis_tready` (50%) with `pkt_length = 3`: no data loss or reorder, outputs stable during stall, tlast every 3rd beat.
- `pkt_length` changed from 4 to 2 mid-packet: the current packet stays at 4 beats and following packets are 2 beats.
- `resetn` low for 1 cycle mid-packet with a beat in PEND and OUT:
  - all outputs 0 next cycle;
  - the next packet is a full `pkt_length` long.
